// File: rtl/arb_mux.sv
// ============================================================================
// Module   : arb_mux
// Purpose  : N-channel arbitrating mux (fixed priority or round-robin) with a
//            registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 2,
    parameter int RR    = 0,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    localparam logic [SELW-1:0] c_last = SELW'(N - 1);
    localparam logic [SELW-1:0] c_one  = SELW'(1);

    logic                r_out_valid_q;
    logic [WIDTH-1:0]    r_out_data_q;
    logic [SELW-1:0]     r_out_sel_q;
    logic [SELW-1:0]     r_ptr_q;

    logic                w_out_valid_d;
    logic [WIDTH-1:0]    w_out_data_d;
    logic [SELW-1:0]     w_out_sel_d;
    logic [SELW-1:0]     w_ptr_d;

    logic                w_load;
    logic                w_any;
    logic                w_take;
    logic [SELW-1:0]     w_base;
    logic [SELW-1:0]     w_grant;
    logic [WIDTH-1:0]    w_sel_data;
    int                  w_idx;

    assign w_load = !r_out_valid_q || out_ready;
    assign w_base = (RR != 0) ? r_ptr_q : '0;

    // Search downward from the farthest offset so the nearest valid channel
    // (relative to the base) is the last one written and therefore wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(w_base) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (in_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = SELW'(w_idx);
            end
        end
    end

    assign w_take     = w_load && w_any && !rst;
    assign w_sel_data = in_data[int'(w_grant)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (w_take) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_out_data_d  = r_out_data_q;
        w_out_sel_d   = r_out_sel_q;
        w_ptr_d       = r_ptr_q;
        if (w_load) begin
            if (w_any) begin
                w_out_valid_d = 1'b1;
                w_out_data_d  = w_sel_data;
                w_out_sel_d   = w_grant;
                if (RR != 0) begin
                    w_ptr_d = (w_grant == c_last) ? '0 : w_grant + c_one;
                end
            end else begin
                w_out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_out_sel_q   <= '0;
            r_ptr_q       <= '0;
        end else begin
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_out_sel_q   <= w_out_sel_d;
            r_ptr_q       <= w_ptr_d;
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_data  = r_out_data_q;
    assign out_sel   = r_out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_mux.sv
// ============================================================================
// Module   : tb_arb_mux
// Purpose  : Self-checking bench for arb_mux in three configurations
//            (N=4 fixed, N=4 round-robin, N=3 round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  iv   [3];
    logic [31:0] id   [3][4];
    logic        ordy [3];

    logic [3:0]  ir0, ir1;
    logic [2:0]  ir2;
    logic [31:0] od0, od1, od2;
    logic        ov0, ov1, ov2;
    logic [1:0]  os0, os1, os2;

    int n_checks = 0;
    int n_err    = 0;

    // Model of the output register contents and round-robin pointer per DUT
    logic        m_valid [3];
    logic [31:0] m_data  [3];
    int          m_sel   [3];
    int          m_ptr   [3];

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(32), .N(4), .RR(0)) u_fix4 (
        .clk(clk), .rst(rst),
        .in_data({id[0][3], id[0][2], id[0][1], id[0][0]}),
        .in_valid(iv[0]), .in_ready(ir0),
        .out_data(od0), .out_valid(ov0), .out_ready(ordy[0]), .out_sel(os0)
    );

    arb_mux #(.WIDTH(32), .N(4), .RR(1)) u_rr4 (
        .clk(clk), .rst(rst),
        .in_data({id[1][3], id[1][2], id[1][1], id[1][0]}),
        .in_valid(iv[1]), .in_ready(ir1),
        .out_data(od1), .out_valid(ov1), .out_ready(ordy[1]), .out_sel(os1)
    );

    arb_mux #(.WIDTH(32), .N(3), .RR(1)) u_rr3 (
        .clk(clk), .rst(rst),
        .in_data({id[2][2], id[2][1], id[2][0]}),
        .in_valid(iv[2][2:0]), .in_ready(ir2),
        .out_data(od2), .out_valid(ov2), .out_ready(ordy[2]), .out_sel(os2)
    );

    function automatic int ch_n(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic bit is_rr(input int d);
        return d != 0;
    endfunction

    // First valid channel in search order starting at the model pointer
    function automatic int first_valid(input int d);
        int n;
        int base;
        n    = ch_n(d);
        base = is_rr(d) ? m_ptr[d] : 0;
        for (int k = 0; k < n; k++) begin
            if (iv[d][(base + k) % n]) return (base + k) % n;
        end
        return -1;
    endfunction

    function automatic int exp_grant(input int d);
        if (rst) return -1;
        if (m_valid[d] && !ordy[d]) return -1;
        return first_valid(d);
    endfunction

    function automatic logic [31:0] get_ir(input int d);
        case (d)
            0:       return {28'd0, ir0};
            1:       return {28'd0, ir1};
            default: return {29'd0, ir2};
        endcase
    endfunction

    function automatic logic [31:0] get_od(input int d);
        case (d)
            0:       return od0;
            1:       return od1;
            default: return od2;
        endcase
    endfunction

    function automatic logic [31:0] get_ov(input int d);
        case (d)
            0:       return {31'd0, ov0};
            1:       return {31'd0, ov1};
            default: return {31'd0, ov2};
        endcase
    endfunction

    function automatic logic [31:0] get_os(input int d);
        case (d)
            0:       return {30'd0, os0};
            1:       return {30'd0, os1};
            default: return {30'd0, os2};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                m_valid[d] <= 1'b0;
                m_data[d]  <= '0;
                m_sel[d]   <= 0;
                m_ptr[d]   <= 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (!m_valid[d] || ordy[d]) begin
                    if (first_valid(d) >= 0) begin
                        m_valid[d] <= 1'b1;
                        m_data[d]  <= id[d][first_valid(d)];
                        m_sel[d]   <= first_valid(d);
                        if (is_rr(d)) m_ptr[d] <= (first_valid(d) + 1) % ch_n(d);
                    end else begin
                        m_valid[d] <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("model_in_ready[%0d]", d), get_ir(d),
                (exp_grant(d) < 0) ? 32'd0 : (32'd1 << exp_grant(d)));
            chk($sformatf("model_out_valid[%0d]", d), get_ov(d), {31'd0, m_valid[d]});
            chk($sformatf("model_out_data[%0d]", d), get_od(d), m_data[d]);
            chk($sformatf("model_out_sel[%0d]", d), get_os(d), 32'(m_sel[d]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rr_seq [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d]      = '0;
            ordy[d]    = 1'b1;
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_sel[d]   = 0;
            m_ptr[d]   = 0;
            for (int i = 0; i < 4; i++) id[d][i] = '0;
        end
        step();
        step();
        chk("reset_out_valid", {31'd0, ov0}, 32'd0);
        chk("reset_out_data", od0, 32'd0);
        rst = 1'b0;
        step();

        // Fixed priority: channel 1 beats channel 3
        iv[0]    = 4'b1010;
        id[0][1] = 32'h1111_1111;
        id[0][3] = 32'h3333_3333;
        #1;
        chk("fix_in_ready_1", {28'd0, ir0}, 32'h2);
        step();
        chk("fix_out_data_1", od0, 32'h1111_1111);
        chk("fix_out_sel_1", {30'd0, os0}, 32'd1);
        chk("fix_out_valid_1", {31'd0, ov0}, 32'd1);
        iv[0] = 4'b1000;
        #1;
        chk("fix_in_ready_3", {28'd0, ir0}, 32'h8);
        step();
        chk("fix_out_data_3", od0, 32'h3333_3333);
        chk("fix_out_sel_3", {30'd0, os0}, 32'd3);
        iv[0] = 4'b0000;
        step();
        chk("idle_out_valid", {31'd0, ov0}, 32'd0);
        chk("idle_out_data_held", od0, 32'h3333_3333);

        // Round-robin fairness, all channels continuously valid
        iv[1] = 4'b1111;
        for (int i = 0; i < 4; i++) id[1][i] = 32'hA0 + i;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_in_ready", {28'd0, ir1}, {28'd0, 4'b0001 << rr_seq[k]});
            step();
            chk("rr_out_sel", {30'd0, os1}, 32'(rr_seq[k]));
            chk("rr_out_data", od1, 32'hA0 + 32'(rr_seq[k]));
        end
        iv[1] = 4'b0000;
        step();

        // Round-robin wrap and skip, N=3
        for (int i = 0; i < 3; i++) id[2][i] = 32'h20 + i;
        iv[2] = 4'b0010;
        step();
        chk("rr3_setup_sel", {30'd0, os2}, 32'd1);
        iv[2] = 4'b0001;
        #1;
        chk("rr3_wrap_in_ready", {29'd0, ir2}, 32'h1);
        step();
        chk("rr3_wrap_sel", {30'd0, os2}, 32'd0);
        iv[2] = 4'b0101;
        #1;
        chk("rr3_skip_in_ready", {29'd0, ir2}, 32'h4);
        step();
        chk("rr3_skip_sel", {30'd0, os2}, 32'd2);
        chk("rr3_skip_data", od2, 32'h22);
        iv[2] = 4'b0000;
        step();

        // Backpressure with channel 0 waiting
        id[0][0] = 32'hDEAD_BEEF;
        iv[0]    = 4'b0001;
        step();
        id[0][0] = 32'h0000_0C0C;
        ordy[0]  = 1'b0;
        repeat (5) begin
            #1;
            chk("bp_in_ready", {28'd0, ir0}, 32'd0);
            chk("bp_out_data", od0, 32'hDEAD_BEEF);
            chk("bp_out_valid", {31'd0, ov0}, 32'd1);
            step();
        end
        ordy[0] = 1'b1;
        #1;
        chk("bp_release_in_ready", {28'd0, ir0}, 32'h1);
        step();
        chk("bp_release_data", od0, 32'h0000_0C0C);
        chk("bp_release_valid", {31'd0, ov0}, 32'd1);
        iv[0] = 4'b0000;
        step();
        chk("bp_drain_valid", {31'd0, ov0}, 32'd0);

        // Reset mid-stream: pointer was left at 3 before reset
        ordy[1] = 1'b0;
        iv[1]   = 4'b0100;
        step();
        chk("mid_pre_valid", {31'd0, ov1}, 32'd1);
        chk("mid_pre_data", od1, 32'hA2);
        iv[1] = 4'b1100;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, ov1}, 32'd0);
        chk("mid_rst_data", od1, 32'd0);
        chk("mid_rst_sel", {30'd0, os1}, 32'd0);
        chk("mid_rst_in_ready", {28'd0, ir1}, 32'd0);
        step();
        rst     = 1'b0;
        ordy[1] = 1'b1;
        #1;
        chk("mid_ptr_cleared", {28'd0, ir1}, 32'h4);
        step();
        chk("mid_post_sel", {30'd0, os1}, 32'd2);
        iv[1] = 4'b0000;
        step();
        step();
        chk("mid_idle_valid", {31'd0, ov1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
